dffram_arbiter: RTL and testbench

- Shares the single-port 4096x32 DFFRAM between two ibex-style requesters: instruction fetch (port I) and load/store (port D).
- Performs address decode/range check, grant arbitration, byte-mask write forwarding and response routing.
- Covers the RAM's 1-cycle read latency.
- Sits between the core bus ports and the DFFRAM instance in the memory subsystem.

---
 rtl/dffram_arb_pkg.sv | 28 ++
 rtl/dffram_arb_prio.sv | 48 ++++
 rtl/dffram_arbiter.sv | 89 ++++++++
 tb/tb_dffram_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dffram_arb_pkg.sv
// dffram_arb_pkg: shared types and constants for the DFFRAM arbiter slice.
package dffram_arb_pkg;

    localparam int DFFRAM_DEPTH = 4096;
    localparam int DFFRAM_AW    = 12;

    // Bit positions of each requester inside req/gnt vectors
    localparam int IDX_I = 0;
    localparam int IDX_D = 1;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_I    = 2'd1,
        REQ_D    = 2'd2
    } requester_t;

    typedef struct packed {
        logic       valid;
        requester_t port;
        logic       err;
        logic       we;
    } resp_t;

    function automatic requester_t winner(input logic [1:0] gnt);
        return gnt[IDX_D] ? REQ_D : gnt[IDX_I] ? REQ_I : REQ_NONE;
    endfunction

endpackage

// File: rtl/dffram_arb_prio.sv
// dffram_arb_prio: two-requester grant logic, D-priority with a starvation guard for I,
// or strict round-robin when DFFRAM_ARB_RR_EN is defined.
module dffram_arb_prio
    import dffram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

`ifdef DFFRAM_ARB_RR_EN
    logic contest;
    logic last_d;

    assign contest    = req[IDX_I] & req[IDX_D];
    assign gnt[IDX_I] = req[IDX_I] & (~req[IDX_D] | last_d);
    assign gnt[IDX_D] = req[IDX_D] & ~gnt[IDX_I];

    // Resetting to D hands the first contest to I
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni)
            last_d <= 1'b1;
        else if (contest)
            last_d <= gnt[IDX_D];
`else
    localparam int CW = $clog2(STARVE_LIMIT + 2);

    logic [CW-1:0] cnt;
    logic          starved;

    assign starved    = cnt == CW'(STARVE_LIMIT);
    assign gnt[IDX_I] = req[IDX_I] & (~req[IDX_D] | starved);
    assign gnt[IDX_D] = req[IDX_D] & ~gnt[IDX_I];

    // Counts consecutive denied cycles of I and saturates at the limit
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni)
            cnt <= '0;
        else if (!req[IDX_I] || gnt[IDX_I])
            cnt <= '0;
        else if (!starved)
            cnt <= cnt + 1'b1;
`endif

endmodule

// File: rtl/dffram_arbiter.sv
// dffram_arbiter: shares one single-port DFFRAM between ibex I and D ports.
// Define DFFRAM_ARB_RR_EN for round-robin arbitration instead of D-priority.
module dffram_arbiter
    import dffram_arb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int          DEPTH        = DFFRAM_DEPTH,
    parameter int          AW           = $clog2(DEPTH),
    parameter int          STARVE_LIMIT = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          i_req_i,
    output logic          i_gnt_o,
    input  logic [31:0]   i_addr_i,
    output logic          i_rvalid_o,
    output logic [31:0]   i_rdata_o,
    output logic          i_err_o,
    input  logic          d_req_i,
    output logic          d_gnt_o,
    input  logic          d_we_i,
    input  logic [3:0]    d_be_i,
    input  logic [31:0]   d_addr_i,
    input  logic [31:0]   d_wdata_i,
    output logic          d_rvalid_o,
    output logic [31:0]   d_rdata_o,
    output logic          d_err_o,
    output logic          ram_en_o,
    output logic [3:0]    ram_we_o,
    output logic [31:0]   ram_di_o,
    output logic [AW-1:0] ram_a_o,
    input  logic [31:0]   ram_do_i
);

    localparam logic [31:0] SPAN = 32'(DEPTH * 4);

    logic [31:0] i_off, d_off, a_off, rdata;
    logic        i_in, d_in;
    logic [1:0]  arb_gnt, gnt;
    resp_t       resp, resp_nxt;

    // Unsigned offset makes addresses below the base wrap out of range too
    assign i_off = i_addr_i - BASE_ADDR;
    assign d_off = d_addr_i - BASE_ADDR;
    assign i_in  = i_off < SPAN;
    assign d_in  = d_off < SPAN;

    dffram_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req    ({d_req_i, i_req_i}),
        .gnt    (arb_gnt)
    );

    // Grants are suppressed while reset is held so every output idles at 0
    assign gnt     = arb_gnt & {2{rst_ni}};
    assign i_gnt_o = gnt[IDX_I];
    assign d_gnt_o = gnt[IDX_D];

    assign a_off    = d_gnt_o ? d_off : i_off;
    assign ram_a_o  = AW'(a_off >> 2);
    assign ram_en_o = (i_gnt_o & i_in) | (d_gnt_o & d_in);
    assign ram_we_o = (d_gnt_o & d_in & d_we_i) ? d_be_i : 4'b0;
    assign ram_di_o = d_wdata_i;

    assign resp_nxt = '{
        valid: |gnt,
        port:  winner(gnt),
        err:   d_gnt_o ? ~d_in : i_gnt_o & ~i_in,
        we:    d_gnt_o & d_we_i
    };

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni)
            resp <= '0;
        else
            resp <= resp_nxt;

    assign rdata      = (resp.err | resp.we) ? 32'b0 : ram_do_i;
    assign i_rvalid_o = resp.valid & (resp.port == REQ_I);
    assign d_rvalid_o = resp.valid & (resp.port == REQ_D);
    assign i_rdata_o  = i_rvalid_o ? rdata : 32'b0;
    assign d_rdata_o  = d_rvalid_o ? rdata : 32'b0;
    assign i_err_o    = i_rvalid_o & resp.err;
    assign d_err_o    = d_rvalid_o & resp.err;

endmodule

// File: tb/tb_dffram_arbiter.sv
// tb_dffram_arbiter: random and directed checks of dffram_arbiter against a transaction-level model.
module tb_dffram_arbiter;

    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam int          STARVE = 4;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic        i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err, ram_en;
    logic [31:0] i_rdata, d_rdata, ram_di, ram_do;
    logic [3:0]  ram_we;
    logic [11:0] ram_a;

    int tests = 0, errors = 0;

    always #5 clk = ~clk;

    dffram_arbiter dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .i_req_i(i_req), .i_gnt_o(i_gnt), .i_addr_i(i_addr),
        .i_rvalid_o(i_rvalid), .i_rdata_o(i_rdata), .i_err_o(i_err),
        .d_req_i(d_req), .d_gnt_o(d_gnt), .d_we_i(d_we), .d_be_i(d_be),
        .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata), .d_err_o(d_err),
        .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_di_o(ram_di),
        .ram_a_o(ram_a), .ram_do_i(ram_do)
    );

    function automatic logic [31:0] seed_word(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    // Single-port RAM with byte mask and 1-cycle read latency
    logic [31:0] ram [4096];
    initial begin
        ram_do = '0;
        for (int i = 0; i < 4096; i++) ram[i] = seed_word(i);
        forever begin
            @(posedge clk);
            if (ram_en) begin
                for (int b = 0; b < 4; b++)
                    if (ram_we[b]) ram[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
                ram_do <= ram[ram_a];
            end
        end
    end

    // Reference model state
    logic [31:0] ref_mem [4096];
    bit          p_vi, p_vd, p_err;
    logic [31:0] p_data;
    int          denied;
    bit          i_turn;
    bit          obs_gi, obs_gd, obs_en;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        p_vi = 0; p_vd = 0; p_err = 0; p_data = '0;
        denied = 0; i_turn = 1;
    endtask

    task automatic step(input bit ri, input logic [31:0] ia, input bit rd, input bit we,
                        input logic [3:0] be, input logic [31:0] da, input logic [31:0] wd);
        bit gi, gd, iin, din, en, n_err;
        int w;
        logic [31:0] n_data;
        i_req = ri; i_addr = ia; d_req = rd; d_we = we; d_be = be; d_addr = da; d_wdata = wd;
        #1;
`ifdef DFFRAM_ARB_RR_EN
        gi = ri && (!rd || i_turn);
`else
        gi = ri && (!rd || denied >= STARVE);
`endif
        gd  = rd && !gi;
        iin = (ia - BASE) < 32'h4000;
        din = (da - BASE) < 32'h4000;
        en  = (gi && iin) || (gd && din);
        w   = int'(((gd ? da : ia) - BASE) >> 2);
        obs_gi = i_gnt; obs_gd = d_gnt; obs_en = ram_en;
        check("gnt_i", 32'(i_gnt), 32'(gi));
        check("gnt_d", 32'(d_gnt), 32'(gd));
        check("ram_en", 32'(ram_en), 32'(en));
        if (en) begin
            check("ram_a", 32'(ram_a), 32'(w));
            check("ram_we", 32'(ram_we), (gd && we) ? 32'(be) : 32'd0);
        end
        if (en && gd && we) check("ram_di", ram_di, wd);
        check("rvalid_i", 32'(i_rvalid), 32'(p_vi));
        check("rvalid_d", 32'(d_rvalid), 32'(p_vd));
        check("err_i", 32'(i_err), 32'(p_vi && p_err));
        check("err_d", 32'(d_err), 32'(p_vd && p_err));
        check("rdata_i", i_rdata, p_vi ? p_data : 32'd0);
        check("rdata_d", d_rdata, p_vd ? p_data : 32'd0);
        n_err  = (gi && !iin) || (gd && !din);
        n_data = '0;
        if (en && !(gd && we)) n_data = ref_mem[w];
        if (en && gd && we)
            for (int b = 0; b < 4; b++) if (be[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
        denied = (ri && !gi) ? denied + 1 : 0;
        if (ri && rd) i_turn = gd;
        @(posedge clk);
        #1;
        p_vi = gi; p_vd = gd; p_err = n_err; p_data = n_data;
    endtask

    function automatic logic [31:0] rand_addr();
        int r = $urandom_range(0, 7);
        if (r == 0) return BASE + 32'h4000 + 32'($urandom_range(0, 1023));
        if (r == 1) return BASE - 32'd4;
        return BASE + 32'($urandom_range(0, 15) << 2) + 32'($urandom_range(0, 3));
    endfunction

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = seed_word(i);
        model_reset();
        #1;
        check("reset_rvalid_i", 32'(i_rvalid), 0);
        check("reset_rvalid_d", 32'(d_rvalid), 0);
        check("reset_rdata_i", i_rdata, 0);
        check("reset_rdata_d", d_rdata, 0);
        check("reset_err", 32'(i_err | d_err), 0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // Write then read back through the other port
        step(0, BASE, 1, 1, 4'hF, BASE + 32'h10, 32'hDEAD_BEEF);
        check("t1_d_rvalid", 32'(d_rvalid), 1);
        check("t1_d_rdata", d_rdata, 0);
        step(1, BASE + 32'h10, 0, 0, 4'h0, BASE, 32'h0);
        check("t1_i_rvalid", 32'(i_rvalid), 1);
        check("t1_i_rdata", i_rdata, 32'hDEAD_BEEF);

        // Byte-enable merge
        step(0, BASE, 1, 1, 4'hF, BASE + 32'h20, 32'h1122_3344);
        step(0, BASE, 1, 1, 4'b0010, BASE + 32'h20, 32'h0000_AA00);
        step(0, BASE, 1, 0, 4'h0, BASE + 32'h20, 32'h0);
        check("t2_merge", d_rdata, 32'h1122_AA44);

        // Contested grant sequence
        for (int k = 0; k < 10; k++) begin
            step(1, BASE + 32'h40, 1, 0, 4'h0, BASE + 32'h44, 32'h0);
`ifdef DFFRAM_ARB_RR_EN
            check("t3_seq_i", 32'(obs_gi), 32'(k % 2 == 0));
`else
            check("t3_seq_i", 32'(obs_gi), 32'(k % 5 == 4));
`endif
        end

        // Out-of-range data read
        step(0, BASE, 1, 0, 4'h0, BASE + 32'h4000, 32'h0);
        check("t4_gnt_d", 32'(obs_gd), 1);
        check("t4_ram_en", 32'(obs_en), 0);
        check("t4_rvalid_d", 32'(d_rvalid), 1);
        check("t4_err_d", 32'(d_err), 1);
        check("t4_rdata_d", d_rdata, 0);

        // Back-to-back instruction reads
        for (int k = 0; k < 4; k++) begin
            step(1, BASE + 32'(4 * k), 0, 0, 4'h0, BASE, 32'h0);
            check("t6_rvalid_i", 32'(i_rvalid), 1);
            check("t6_rdata_i", i_rdata, seed_word(k));
        end
        step(0, BASE, 0, 0, 4'h0, BASE, 32'h0);

        // Reset while a port I response is in flight
        i_req = 1; i_addr = BASE + 32'h8; d_req = 0;
        #1;
        check("t5_pre_gnt", 32'(i_gnt), 1);
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        check("t5_gnt_i", 32'(i_gnt), 0);
        check("t5_ram_en", 32'(ram_en), 0);
        check("t5_rvalid", 32'(i_rvalid | d_rvalid), 0);
        check("t5_rdata", i_rdata | d_rdata, 0);
        check("t5_err", 32'(i_err | d_err), 0);
        @(posedge clk);
        #1;
        check("t5_hold_rvalid", 32'(i_rvalid), 0);
        i_req = 0;
        @(negedge clk);
        rst_ni = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check("t5_post_rvalid", 32'(i_rvalid), 0);
        for (int k = 0; k < 5; k++) begin
            step(1, BASE, 1, 0, 4'h0, BASE + 32'h4, 32'h0);
`ifdef DFFRAM_ARB_RR_EN
            check("t5_seq_i", 32'(obs_gi), 32'(k % 2 == 0));
`else
            check("t5_seq_i", 32'(obs_gi), 32'(k == 4));
`endif
        end

        // Random traffic
        for (int n = 0; n < 600; n++)
            step(1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 4'($urandom), rand_addr(), $urandom);
        step(0, BASE, 0, 0, 4'h0, BASE, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
